// File: rtl/disp_scheduler_pkg.sv
// Shared display types: scheduler FSM states, the digit value type and a
// small elaboration-time helper.
package disp_scheduler_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } disp_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/disp_scheduler_if.sv
// Key-push handshake and buffer clear between a requester and the digit scheduler.
interface disp_scheduler_if;
    import disp_scheduler_pkg::*;

    logic   push_valid;
    digit_t push_data;
    logic   push_ready;
    logic   clear;

    modport master (output push_valid, output push_data, output clear, input push_ready);
    modport slave  (input push_valid, input push_data, input clear, output push_ready);

endinterface

// File: rtl/disp_scheduler.sv
// Multiplexed seven-segment digit scheduler: shows one buffered digit per slot
// with a blanking gap between slots, and accepts new key values only while blanking.
module disp_scheduler
    import disp_scheduler_pkg::*;
#(
    parameter int unsigned NDIG  = 4,
    parameter int unsigned DWELL = 50,
    parameter int unsigned BLANK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    disp_scheduler_if.slave   push,
    output digit_t            num_out,
    output logic [NDIG-1:0]   disp_en
);

    // A floor of 2 keeps the tick counter at least one bit wide.
    localparam int unsigned TMAX = max_u(max_u(DWELL, BLANK), 2);
    localparam int unsigned TW   = $clog2(TMAX);
    localparam int unsigned IW   = $clog2(NDIG);
    localparam int unsigned LW   = $clog2(NDIG + 1);

    disp_state_e   state_q;
    logic [TW-1:0] tcnt_q;
    logic [IW-1:0] idx_q;
    logic [LW-1:0] len_q;
    digit_t        dig_q [NDIG];
    logic          push_fire;

    assign push.push_ready = (state_q == S_BLANK) && !push.clear;
    assign push_fire       = push.push_valid && push.push_ready;

    // Slot timing: blank gap, then dwell on the current digit, then advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_BLANK;
            tcnt_q  <= '0;
            idx_q   <= '0;
        end else if (tick) begin
            case (state_q)
                S_BLANK: begin
                    if (tcnt_q == TW'(BLANK - 1)) begin
                        state_q <= S_SHOW;
                        tcnt_q  <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_SHOW: begin
                    if (tcnt_q == TW'(DWELL - 1)) begin
                        state_q <= S_BLANK;
                        tcnt_q  <= '0;
                        idx_q   <= (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_BLANK;
                    tcnt_q  <= '0;
                end
            endcase
        end
    end

    // Digit shift buffer; clear wins over a simultaneous push.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NDIG; i++) dig_q[i] <= '0;
            len_q <= '0;
        end else if (push.clear) begin
            for (int unsigned i = 0; i < NDIG; i++) dig_q[i] <= '0;
            len_q <= '0;
        end else if (push_fire) begin
            dig_q[0] <= push.push_data;
            for (int unsigned i = 1; i < NDIG; i++) dig_q[i] <= dig_q[i-1];
            if (len_q != LW'(NDIG)) len_q <= len_q + LW'(1);
        end
    end

    // Value is presented during blanking too so the decoder settles before the enable.
    assign num_out = dig_q[idx_q];

    always_comb begin
        disp_en = '0;
        if ((state_q == S_SHOW) && (LW'(idx_q) < len_q)) disp_en[idx_q] = 1'b1;
    end

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with NDIG=4, DWELL=3, BLANK=1.
module tb_disp_scheduler;
    import disp_scheduler_pkg::*;

    localparam int unsigned NDIG  = 4;
    localparam int unsigned DWELL = 3;
    localparam int unsigned BLANK = 1;

    logic            clk;
    logic            reset;
    logic            tick;
    digit_t          num_out;
    logic [NDIG-1:0] disp_en;

    int checks   = 0;
    int errors   = 0;
    int tick_div = 1;
    int cyc      = 0;

    disp_scheduler_if push_if ();

    disp_scheduler #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .push    (push_if.slave),
        .num_out (num_out),
        .disp_en (disp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tick_div: 0 = no ticks, N = one tick every N cycles
    initial begin
        tick = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (tick_div == 0) tick = 1'b0;
            else tick = ((cyc % tick_div) == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_push(input int d);
        int n;
        n = 0;
        @(negedge clk);
        push_if.push_valid = 1'b1;
        push_if.push_data  = 4'(d);
        while (!push_if.push_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!push_if.push_ready) chk("push_timeout", 32'(push_if.push_ready), 1);
        @(negedge clk);
        push_if.push_valid = 1'b0;
    endtask

    task automatic wait_en(input int v);
        int n;
        n = 0;
        while (32'(disp_en) != 32'(v) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (32'(disp_en) != 32'(v)) chk("wait_en_timeout", 32'(disp_en), 32'(v));
    endtask

    // Park on the first cycle of digit 0's show slot.
    task automatic sync_slot0();
        wait_en(0);
        wait_en(1);
    endtask

    // One full 16-cycle frame with all four digits lit.
    task automatic check_rotation(input int b0, input int b1, input int b2, input int b3,
                                  input string tg);
        int b[4];
        int s, exp_en, exp_num;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            s = c / 4;
            if ((c % 4) < 3) begin
                exp_en  = 1 << s;
                exp_num = b[s];
            end else begin
                exp_en  = 0;
                exp_num = b[(s + 1) % 4];
            end
            chk($sformatf("%s_en_c%0d", tg, c), 32'(disp_en), exp_en);
            chk($sformatf("%s_num_c%0d", tg, c), 32'(num_out), exp_num);
        end
    endtask

    initial begin
        int n, m, exp_en, exp_num, exp_rdy;

        reset              = 1'b0;
        push_if.push_valid = 1'b0;
        push_if.push_data  = '0;
        push_if.clear      = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_en", 32'(disp_en), 0);
        chk("rst_num", 32'(num_out), 0);
        chk("rst_ready", 32'(push_if.push_ready), 1);
        reset = 1'b1;

        // Four pushes then a full frame
        do_push(1); do_push(2); do_push(3); do_push(4);
        sync_slot0();
        check_rotation(4, 3, 2, 1, "rot4");

        // Fifth push drops the oldest digit
        do_push(8);
        sync_slot0();
        check_rotation(8, 4, 3, 2, "rot5");

        // Push held through a show slot is accepted once, at the next blank
        do_reset();
        do_push(1);
        sync_slot0();
        push_if.push_valid = 1'b1;
        push_if.push_data  = 4'd7;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) push_if.push_valid = 1'b0;
            exp_rdy = (c == 3 || c == 7) ? 1 : 0;
            exp_en  = (c < 3) ? 1 : ((c >= 4 && c <= 6) ? 2 : 0);
            exp_num = (c < 3 || (c >= 4 && c <= 6)) ? 1 : 0;
            chk($sformatf("hold_ready_c%0d", c), 32'(push_if.push_ready), exp_rdy);
            chk($sformatf("hold_en_c%0d", c), 32'(disp_en), exp_en);
            chk($sformatf("hold_num_c%0d", c), 32'(num_out), exp_num);
        end

        // Single digit: slots 1..3 dark, 16-cycle period
        do_reset();
        do_push(5);
        sync_slot0();
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            exp_en  = ((c % 16) < 3) ? 1 : 0;
            exp_num = (((c % 16) < 3) || ((c % 16) == 15)) ? 5 : 0;
            chk($sformatf("one_en_c%0d", c), 32'(disp_en), exp_en);
            chk($sformatf("one_num_c%0d", c), 32'(num_out), exp_num);
        end

        // Clear with a simultaneous push
        @(negedge clk);
        push_if.clear      = 1'b1;
        push_if.push_valid = 1'b1;
        push_if.push_data  = 4'd9;
        chk("clr_ready", 32'(push_if.push_ready), 0);
        @(negedge clk);
        push_if.clear      = 1'b0;
        push_if.push_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("clr_en_c%0d", c), 32'(disp_en), 0);
            chk($sformatf("clr_num_c%0d", c), 32'(num_out), 0);
            @(negedge clk);
        end

        // Slow ticks stretch the slots
        do_reset();
        do_push(1); do_push(2);
        tick_div = 4;
        repeat (20) @(negedge clk);
        sync_slot0();
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (32'(disp_en) != 1) break;
            n++;
        end
        chk("slow_show_len", 32'(n), 12);
        m = 0;
        for (int k = 0; k < 100; k++) begin
            if (32'(disp_en) != 0) break;
            m++;
            @(negedge clk);
        end
        chk("slow_blank_len", 32'(m), 4);
        chk("slow_slot1_en", 32'(disp_en), 2);
        chk("slow_slot1_num", 32'(num_out), 1);

        // Reset mid-show overrides a push; ticks parked so idx stays put afterwards
        repeat (4) @(negedge clk);
        reset              = 1'b0;
        tick_div           = 0;
        push_if.push_valid = 1'b1;
        push_if.push_data  = 4'hF;
        @(negedge clk);
        chk("midrst_en", 32'(disp_en), 0);
        chk("midrst_num", 32'(num_out), 0);
        chk("midrst_ready", 32'(push_if.push_ready), 1);
        reset              = 1'b1;
        push_if.push_valid = 1'b0;
        @(negedge clk);
        chk("midrst_num_after", 32'(num_out), 0);
        do_push(6); do_push(7);
        chk("idx0_num", 32'(num_out), 7);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("notick_en_c%0d", c), 32'(disp_en), 0);
        end
        tick_div = 1;
        for (int k = 0; k < 50; k++) begin
            if (32'(disp_en) != 0) break;
            @(negedge clk);
        end
        chk("first_lit_en", 32'(disp_en), 1);
        chk("first_lit_num", 32'(num_out), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
